// File: rtl/cpu_0_oci_pkg.sv
// Shared constants and types for the OCI direct-control-transfer trace path.
package cpu_0_oci_pkg;

    localparam int DCT_W   = 30;
    localparam int CODE_W  = 2;
    localparam int CNT_W   = 4;
    localparam int DEPTH   = DCT_W / CODE_W;
    localparam int FRAME_W = CNT_W + DCT_W;

    // A frame is {count, buffer}; the buffer occupies the low bits.
    localparam int FRAME_BUF_LSB = 0;
    localparam int FRAME_CNT_LSB = DCT_W;

    localparam logic [CODE_W-1:0] DCT_ILLEGAL   = 2'b00;
    localparam logic [CODE_W-1:0] DCT_TAKEN     = 2'b01;
    localparam logic [CODE_W-1:0] DCT_NOT_TAKEN = 2'b10;
    localparam logic [CODE_W-1:0] DCT_EXC       = 2'b11;

    localparam logic [CNT_W-1:0] DCT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [DCT_W-1:0] buffer;
    } dct_frame_t;

    function automatic logic dct_code_legal(input logic [CODE_W-1:0] c);
        return c != DCT_ILLEGAL;
    endfunction

endpackage

// File: rtl/cpu_0_oci_dct_frame_reg.sv
// Single-entry valid/ready frame register feeding the trace FIFO.
module cpu_0_oci_dct_frame_reg
    import cpu_0_oci_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  dct_frame_t load_frame_i,
    input  logic       frame_ready_i,
    output logic       slot_free_o,
    output logic       frame_valid_o,
    output dct_frame_t frame_o
);

    logic       valid_q, valid_d;
    dct_frame_t frame_q, frame_d;

    // The slot can take a new frame when empty or when its current frame leaves this cycle.
    assign slot_free_o = !valid_q || frame_ready_i;

    always_comb begin
        valid_d = valid_q;
        frame_d = frame_q;
        if (load_i) begin
            valid_d = 1'b1;
            frame_d = load_frame_i;
        end else if (frame_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            frame_q <= '0;
        end else begin
            valid_q <= valid_d;
            frame_q <= frame_d;
        end
    end

    assign frame_valid_o = valid_q;
    assign frame_o       = frame_q;

endmodule

// File: rtl/cpu_0_oci_dct_packer.sv
// Packs 2-bit branch-outcome codes into 30-bit DCT trace frames with flush support.
module cpu_0_oci_dct_packer
    import cpu_0_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               code_valid,
    input  logic [CODE_W-1:0]  code,
    output logic               code_ready,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic [DCT_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               code_err
);

    logic [DCT_W-1:0] buf_q, buf_d, base_buf;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
    logic             flush_pending_q, flush_pending_d;
    logic             flush_done_q, flush_done_d;
    logic             code_err_q, code_err_d;
    logic             slot_free, transfer, accept, insert;
    dct_frame_t       live_frame, frame_q;

    assign live_frame = '{count: cnt_q, buffer: buf_q};

    assign transfer   = slot_free && ((cnt_q == DCT_FULL) || (flush_pending_q && (cnt_q != '0)));
    assign code_ready = slot_free || ((cnt_q != DCT_FULL) && !flush_pending_q);
    assign accept     = code_valid && code_ready;
    assign insert     = accept && dct_code_legal(code);

    // A transferring buffer is empty for this cycle's insert, so codes keep flowing with no bubble.
    always_comb begin
        base_buf = transfer ? '0 : buf_q;
        base_cnt = transfer ? '0 : cnt_q;
        buf_d    = base_buf;
        cnt_d    = base_cnt;
        if (insert) begin
            buf_d = {base_buf[DCT_W-CODE_W-1:0], code};
            cnt_d = base_cnt + CNT_W'(1);
        end

        code_err_d      = code_err_q || (accept && !dct_code_legal(code));
        flush_pending_d = flush_pending_q;
        flush_done_d    = 1'b0;

        // A flush request arriving while one is pending merges into it.
        if (flush_pending_q) begin
            if (transfer) begin
                flush_pending_d = 1'b0;
                flush_done_d    = 1'b1;
            end
        end else if (flush_req) begin
            if (cnt_d == '0) begin
                flush_done_d = 1'b1;
            end else begin
                flush_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            code_err_q      <= 1'b0;
        end else begin
            buf_q           <= buf_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
            code_err_q      <= code_err_d;
        end
    end

    cpu_0_oci_dct_frame_reg u_frame_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (transfer),
        .load_frame_i (live_frame),
        .frame_ready_i(frame_ready),
        .slot_free_o  (slot_free),
        .frame_valid_o(frame_valid),
        .frame_o      (frame_q)
    );

    assign frame_data = frame_q;
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign flush_done = flush_done_q;
    assign code_err   = code_err_q;

endmodule

// File: tb/tb_cpu_0_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed scenarios plus randomized traffic vs a queue model.
module tb_cpu_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [1:0]  code = 2'b00;
    logic        flush_req = 1'b0;
    logic        frame_ready = 1'b0;
    logic        code_ready;
    logic        flush_done;
    logic        frame_valid;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        code_err;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    // Reference model: the buffer is a plain queue of codes, oldest first.
    logic [1:0]  mq[$];
    bit          mPending, mFv, mErr, mDone;
    logic [33:0] mFd;

    cpu_0_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .code_err   (code_err)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] packFrame();
        logic [29:0] b = '0;
        int n = mq.size();
        for (int i = 0; i < n; i++) b = b | (30'(mq[i]) << (2 * (n - 1 - i)));
        return {4'(n), b};
    endfunction

    function automatic bit modelReady(input bit fr);
        return (!mFv || fr) || ((mq.size() != 15) && !mPending);
    endfunction

    task automatic modelStep();
        bit slotFree, xfer, ready, wasPending, newDone;
        int n = mq.size();
        slotFree   = !mFv || frame_ready;
        ready      = modelReady(frame_ready);
        xfer       = slotFree && ((n == 15) || (mPending && n != 0));
        wasPending = mPending;
        newDone    = 1'b0;
        if (xfer) begin
            mFd = packFrame();
            mFv = 1'b1;
            mq.delete();
            if (mPending) begin
                mPending = 1'b0;
                newDone  = 1'b1;
            end
        end else if (frame_ready) begin
            mFv = 1'b0;
        end
        if (code_valid && ready) begin
            if (code == 2'b00) mErr = 1'b1;
            else mq.push_back(code);
        end
        if (flush_req && !wasPending) begin
            if (mq.size() == 0) newDone = 1'b1;
            else mPending = 1'b1;
        end
        mDone = newDone;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            mPending = 1'b0;
            mFv      = 1'b0;
            mErr     = 1'b0;
            mDone    = 1'b0;
            mFd      = '0;
        end else begin
            modelStep();
        end
    end

    task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [33:0] live;
        live = packFrame();
        expectEq("dct_count",   64'(dct_count),   64'(live[33:30]));
        expectEq("dct_buffer",  64'(dct_buffer),  64'(live[29:0]));
        expectEq("frame_valid", 64'(frame_valid), 64'(mFv));
        expectEq("frame_data",  64'(frame_data),  64'(mFd));
        expectEq("flush_done",  64'(flush_done),  64'(mDone));
        expectEq("code_err",    64'(code_err),    64'(mErr));
        expectEq("code_ready",  64'(code_ready),  64'(modelReady(frame_ready)));
    endtask

    always @(negedge clk) begin
        if (checkEn && reset_n) checkOutput();
    end

    task automatic applyStimulus(input bit v, input logic [1:0] c, input bit f, input bit fr);
        code_valid  = v;
        code        = c;
        flush_req   = f;
        frame_ready = fr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int accepted;
        int cycles;

        repeat (2) @(posedge clk);
        #1;
        expectEq("reset dct_count",   64'(dct_count),   64'd0);
        expectEq("reset dct_buffer",  64'(dct_buffer),  64'd0);
        expectEq("reset frame_valid", 64'(frame_valid), 64'd0);
        expectEq("reset frame_data",  64'(frame_data),  64'd0);
        expectEq("reset flush_done",  64'(flush_done),  64'd0);
        expectEq("reset code_err",    64'(code_err),    64'd0);
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Fifteen taken codes fill the buffer; the frame appears one cycle later.
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
        expectEq("full count", 64'(dct_count), 64'd15);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        expectEq("full frame_valid", 64'(frame_valid), 64'd1);
        expectEq("full frame_data",  64'(frame_data),  64'({4'hF, 30'h15555555}));
        expectEq("full count cleared", 64'(dct_count), 64'd0);
        idle(2);

        // Partial buffer closed by a flush.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
        expectEq("flush no early frame", 64'(frame_valid), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        expectEq("flush frame_valid", 64'(frame_valid), 64'd1);
        expectEq("flush frame_data",  64'(frame_data),  64'({4'h3, 30'h0000001B}));
        expectEq("flush done pulse",  64'(flush_done),  64'd1);
        idle(2);

        // Back-pressure: 30 not-taken codes with the downstream stalled.
        accepted = 0;
        cycles   = 0;
        while (accepted < 30 && cycles < 100) begin
            code_valid  = 1'b1;
            code        = 2'b10;
            flush_req   = 1'b0;
            frame_ready = 1'b0;
            #1;
            if (code_ready) accepted++;
            @(posedge clk);
            #1;
            cycles++;
        end
        expectEq("backpressure accepted", 64'(accepted), 64'd30);
        code_valid = 1'b0;
        #1;
        expectEq("backpressure code_ready", 64'(code_ready), 64'd0);
        expectEq("backpressure held frame", 64'(frame_data), 64'({4'hF, 30'h2AAAAAAA}));
        expectEq("backpressure count", 64'(dct_count), 64'd15);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        expectEq("second frame_valid", 64'(frame_valid), 64'd1);
        expectEq("second frame_data",  64'(frame_data),  64'({4'hF, 30'h2AAAAAAA}));
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        expectEq("drained frame_valid", 64'(frame_valid), 64'd0);
        idle(2);

        // Flush of an empty buffer completes without a frame.
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
        expectEq("empty flush done",  64'(flush_done),  64'd1);
        expectEq("empty flush frame", 64'(frame_valid), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        expectEq("empty flush done cleared", 64'(flush_done), 64'd0);

        // An illegal code is dropped and sets the sticky error.
        expectEq("code_err before", 64'(code_err), 64'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
        expectEq("illegal count", 64'(dct_count), 64'd1);
        expectEq("illegal code_err", 64'(code_err), 64'd1);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        expectEq("illegal frame_data", 64'(frame_data), 64'({4'h2, 30'h00000007}));
        expectEq("illegal err sticky", 64'(code_err), 64'd1);
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            c = ($urandom_range(0, 31) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 3) != 0, c, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset while a frame is held and seven codes are buffered.
        checkEn = 1'b0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        checkEn = 1'b1;
        idle(1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        expectEq("pre-reset frame_valid", 64'(frame_valid), 64'd1);
        expectEq("pre-reset count", 64'(dct_count), 64'd7);
        code_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        expectEq("async frame_valid", 64'(frame_valid), 64'd0);
        expectEq("async frame_data",  64'(frame_data),  64'd0);
        expectEq("async dct_count",   64'(dct_count),   64'd0);
        expectEq("async dct_buffer",  64'(dct_buffer),  64'd0);
        expectEq("async code_err",    64'(code_err),    64'd0);
        expectEq("async flush_done",  64'(flush_done),  64'd0);
        #10;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
            expectEq("post-reset no frame", 64'(frame_valid), 64'd0);
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
